param_fifo_mem: RTL and testbench

//   Parametrised synchronous FIFO buffer on a single-clock dual-port memory array; next generation of the byte RAM-FIFO.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_mem_2p.sv | 33 +++
 rtl/param_fifo_mem.sv | 168 ++++++++++++++++
 tb/tb_param_fifo_mem.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : sizing helpers and FWFT mode constants for param_fifo_mem |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int addr_w(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // One extra bit so the level can represent DEPTH itself.
    function automatic int lvl_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem_2p : DEPTH x DATA_W array, synchronous write, async read    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    localparam int C_ADDR_W = addr_w(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [C_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [C_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Async read sees the pre-edge contents, giving read-before-write on a shared address.
    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/param_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_fifo_mem : parametrised single-clock FIFO with level, flags,   |
// |                  sticky errors and optional first-word-fall-through  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module param_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 2048,
    parameter int AF_LEVEL = 2040,
    parameter int AE_LEVEL = 8,
    parameter int FWFT     = FWFT_OFF,
    localparam int C_ADDR_W = addr_w(DEPTH),
    localparam int C_LVL_W  = lvl_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               rd_en,
    output logic [DATA_W-1:0]  data_out,
    output logic               rd_valid,
    output logic [C_LVL_W-1:0] level,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               busy_mem,
    output logic               overflow,
    output logic               underflow,
    input  logic               err_clr
);

    localparam logic [C_LVL_W-1:0] C_DEPTH = C_LVL_W'(DEPTH);
    localparam logic [C_LVL_W-1:0] C_AF    = C_LVL_W'(AF_LEVEL);
    localparam logic [C_LVL_W-1:0] C_AE    = C_LVL_W'(AE_LEVEL);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_chk_depth
        $error("param_fifo_mem: DEPTH must be a power of two and at least 4");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_chk_levels
        $error("param_fifo_mem: AE_LEVEL must be below AF_LEVEL");
    end
    if (DATA_W < 1) begin : g_chk_width
        $error("param_fifo_mem: DATA_W must be at least 1");
    end

    logic [C_ADDR_W-1:0] r_wr_ptr;
    logic [C_ADDR_W-1:0] r_rd_ptr;
    logic [C_LVL_W-1:0]  r_level;
    logic                r_full;
    logic                r_empty;
    logic                r_af;
    logic                r_ae;
    logic                r_busy;
    logic                r_ovf;
    logic                r_udf;

    logic                w_do_rd;
    logic                w_do_wr;
    logic [C_LVL_W-1:0]  w_level_next;
    logic [DATA_W-1:0]   w_mem_rd;

    // A push into a full FIFO is only safe when the head is leaving the same cycle.
    assign w_do_rd      = rd_en & ~r_empty;
    assign w_do_wr      = wr_en & (~r_full | w_do_rd);
    assign w_level_next = r_level + C_LVL_W'(w_do_wr) - C_LVL_W'(w_do_rd);

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_do_wr),
        .wr_addr (r_wr_ptr),
        .wr_data (data_in),
        .rd_addr (r_rd_ptr),
        .rd_data (w_mem_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + C_ADDR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + C_ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_level <= w_level_next;
            r_full  <= (w_level_next == C_DEPTH);
            r_empty <= (w_level_next == '0);
            r_af    <= (w_level_next >= C_AF);
            r_ae    <= (w_level_next <= C_AE);
            r_busy  <= w_do_wr | w_do_rd;
        end
    end

    // Error flags are sticky; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en & ~w_do_wr) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (rd_en & ~w_do_rd) begin
                r_udf <= 1'b1;
            end else if (err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    if (FWFT == FWFT_ON) begin : g_fwft
        // Gate with empty so the output reads zero after reset instead of stale array contents.
        assign data_out = r_empty ? '0 : w_mem_rd;
        assign rd_valid = ~r_empty;
    end else begin : g_reg_out
        logic [DATA_W-1:0] r_data_out;
        logic              r_rd_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data_out <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_do_rd;
                if (w_do_rd) begin
                    r_data_out <= w_mem_rd;
                end
            end
        end

        assign data_out = r_data_out;
        assign rd_valid = r_rd_valid;
    end

    assign level        = r_level;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign busy_mem     = r_busy;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_param_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_param_fifo_mem : vectors, corner sequences and random traffic     |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_param_fifo_mem;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic [4:0]    level;
    logic          full, empty, almost_full, almost_empty, busy_mem, overflow, underflow;

    logic          f_wr_en = 1'b0;
    logic [DW-1:0] f_data_in = '0;
    logic          f_rd_en = 1'b0;
    logic [DW-1:0] f_data_out;
    logic          f_rd_valid;
    logic [4:0]    f_level;
    logic          f_full, f_empty, f_af, f_ae, f_busy, f_ovf, f_udf;

    always #5 clk = ~clk;

    param_fifo_mem #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .rd_valid(rd_valid), .level(level), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .busy_mem(busy_mem),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    param_fifo_mem #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
        .data_out(f_data_out), .rd_valid(f_rd_valid), .level(f_level), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .busy_mem(f_busy),
        .overflow(f_ovf), .underflow(f_udf), .err_clr(1'b0)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the FIFO contents as a plain queue plus the visible output registers.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_rv = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    typedef struct {
        logic          wr;
        logic [DW-1:0] din;
        logic          rd;
        logic          clr;
        int            lvl;
        logic [DW-1:0] dout;
        logic          rv;
        logic          emp;
        logic          ae;
        logic          udf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_rv   = 1'b0;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_clock(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
        int   n;
        logic acc_rd;
        logic acc_wr;
        n      = q.size();
        acc_rd = rd && (n > 0);
        acc_wr = wr && ((n < DEPTH) || acc_rd);
        m_rv   = acc_rd;
        if (acc_rd) m_dout = q.pop_front();
        if (acc_wr) q.push_back(din);
        m_busy = acc_wr || acc_rd;
        if (wr && !acc_wr) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (rd && !acc_rd) m_udf = 1'b1;
        else if (clr)      m_udf = 1'b0;
    endtask

    task automatic compare_all();
        chk("level",        level,        q.size());
        chk("full",         full,         q.size() == DEPTH);
        chk("empty",        empty,        q.size() == 0);
        chk("almost_full",  almost_full,  q.size() >= AF);
        chk("almost_empty", almost_empty, q.size() <= AE);
        chk("data_out",     data_out,     m_dout);
        chk("rd_valid",     rd_valid,     m_rv);
        chk("busy_mem",     busy_mem,     m_busy);
        chk("overflow",     overflow,     m_ovf);
        chk("underflow",    underflow,    m_udf);
    endtask

    task automatic clock_only(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        err_clr = clr;
        @(posedge clk);
        #1;
        model_clock(wr, din, rd, clr);
    endtask

    task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
        clock_only(wr, din, rd, clr);
        compare_all();
    endtask

    task automatic fstep(input logic wr, input logic [DW-1:0] din, input logic rd);
        f_wr_en   = wr;
        f_data_in = din;
        f_rd_en   = rd;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        f_rd_en = 1'b0;
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int i = 0; i < DEPTH; i++) step(1'b1, base + DW'(i), 1'b0, 1'b0);
    endtask

    initial begin
        //                wr din    rd clr lvl dout   rv emp ae udf
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h44, 1'b1, 1'b0, 2, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset values
        #12;
        model_reset();
        compare_all();
        chk("fwft_rst_data",  f_data_out, 0);
        chk("fwft_rst_valid", f_rd_valid, 0);
        chk("fwft_rst_empty", f_empty,    1);
        @(negedge clk);
        rst_n = 1'b1;

        // First-word-fall-through instance
        fstep(1'b1, 8'h3C, 1'b0);
        chk("fwft_head",      f_data_out, 8'h3C);
        chk("fwft_valid",     f_rd_valid, 1);
        fstep(1'b0, 8'h00, 1'b0);
        chk("fwft_hold",      f_data_out, 8'h3C);
        chk("fwft_hold_lvl",  f_level,    1);
        fstep(1'b0, 8'h00, 1'b1);
        chk("fwft_pop_empty", f_empty,    1);
        chk("fwft_pop_valid", f_rd_valid, 0);
        fstep(1'b1, 8'h01, 1'b0);
        fstep(1'b1, 8'h02, 1'b0);
        chk("fwft_head2",     f_data_out, 8'h01);
        chk("fwft_level2",    f_level,    2);
        fstep(1'b0, 8'h00, 1'b1);
        chk("fwft_next",      f_data_out, 8'h02);
        fstep(1'b0, 8'h00, 1'b1);
        chk("fwft_drained",   f_empty,    1);

        // Table vectors from the empty state
        compare_all();
        for (int i = 0; i < 12; i++) begin
            clock_only(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d_level", i), level,        vecs[i].lvl);
            chk($sformatf("vec%0d_dout", i),  data_out,     vecs[i].dout);
            chk($sformatf("vec%0d_rv", i),    rd_valid,     vecs[i].rv);
            chk($sformatf("vec%0d_empty", i), empty,        vecs[i].emp);
            chk($sformatf("vec%0d_ae", i),    almost_empty, vecs[i].ae);
            chk($sformatf("vec%0d_udf", i),   underflow,    vecs[i].udf);
            chk($sformatf("vec%0d_full", i),  full,         0);
            chk($sformatf("vec%0d_af", i),    almost_full,  0);
        end

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            chk("fill_af", almost_full, (i + 1) >= AF);
        end
        chk("fill_full", full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", data_out, i);
        end
        chk("drain_empty", empty, 1);

        // Pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) step(1'b1, DW'(8'h80 + r * 10 + i), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 8'h00, 1'b1, 1'b0);
                chk("wrap_data", data_out, 8'h80 + r * 10 + i);
            end
            chk("wrap_level", level, 0);
        end

        // Simultaneous push and pop while full
        fill(8'h10);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("fullrw_data",  data_out, 8'h10);
        chk("fullrw_level", level,    16);
        chk("fullrw_ovf",   overflow, 0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullrw_last",  data_out, 8'hAA);

        // Overflow, underflow and clear
        fill(8'h40);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        chk("ovf_set",   overflow, 1);
        chk("ovf_level", level,    16);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("udf_set",   underflow, 1);
        chk("udf_level", level,     1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf",   overflow,  0);
        chk("clr_udf",   underflow, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_data",  data_out,  8'h55);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hC0 + i), (i == 3), 1'b0);
        wr_en = 1'b1;
        rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with drifting push/pop bias
        for (int seg = 0; seg < 4; seg++) begin
            int wp;
            wp = (seg == 0) ? 75 : (seg == 1) ? 25 : 50;
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(99) < wp, DW'($urandom), $urandom_range(99) < (100 - wp),
                     $urandom_range(99) < 5);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
